// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
// Holds the FSM state encoding and a constant log2 used to size counters and pointers.
package wb_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ERR   = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    // Ceiling log2, never below 1 so the result can size a vector directly.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of the shared Wishbone signals: flattened per-master request side plus the single slave port.
// 'slave' is the arbiter's view; 'master' is the view of the masters and the downstream slave.
interface wb_rr_arbiter_if #(
    parameter int NM    = 2,
    parameter int ADR_W = 32,
    parameter int DAT_W = 32
);
    localparam int SEL_W = DAT_W / 8;

    logic [NM-1:0]       m_cyc_i;
    logic [NM-1:0]       m_stb_i;
    logic [NM-1:0]       m_we_i;
    logic [NM*ADR_W-1:0] m_adr_i;
    logic [NM*DAT_W-1:0] m_dat_i;
    logic [NM*SEL_W-1:0] m_sel_i;
    logic [DAT_W-1:0]    m_dat_o;
    logic [NM-1:0]       m_ack_o;
    logic [NM-1:0]       m_err_o;

    logic                s_cyc_o;
    logic                s_stb_o;
    logic                s_we_o;
    logic [ADR_W-1:0]    s_adr_o;
    logic [DAT_W-1:0]    s_dat_o;
    logic [SEL_W-1:0]    s_sel_o;
    logic [DAT_W-1:0]    s_dat_i;
    logic                s_ack_i;
    logic                s_err_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  s_dat_i, s_ack_i, s_err_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output s_dat_i, s_ack_i, s_err_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o
    );

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot grant to the first requester at or after i_ptr,
// wrapping to index 0. Kept generic so other channel arbiters can reuse it.
module wb_rr_arbiter_rr_pick #(
    parameter int NM = 2,
    parameter int PW = 1
) (
    input  logic [NM-1:0] i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [NM-1:0] o_gnt
);

    logic w_found;

    // First pass covers ptr..NM-1; the second only runs when nothing above ptr is requesting.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int j = 0; j < NM; j++) begin
            if (!w_found && i_req[j] && (j >= int'(i_ptr))) begin
                o_gnt[j] = 1'b1;
                w_found  = 1'b1;
            end
        end
        for (int j = 0; j < NM; j++) begin
            if (!w_found && i_req[j]) begin
                o_gnt[j] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter granting whole CYC tenures, with a watchdog that ends a stalled
// slave access with ERR and then drains the master's cycle without touching the slave.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    wb_rr_arbiter_if.slave         bus,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   timeout_o
);

    localparam int NM    = NUM_MASTERS;
    localparam int SEL_W = DAT_W / 8;
    localparam int PW    = clog2(NM);
    localparam int WDW   = clog2(TIMEOUT_CYCLES + 1);
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WD_LAST = WD_EN ? WDW'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_e     r_state, w_state_next;
    logic [NM-1:0]  r_gnt, w_gnt_next;
    logic [PW-1:0]  r_ptr, w_ptr_next;
    logic [WDW-1:0] r_wdog, w_wdog_next;

    logic [NM-1:0]    w_pick;
    logic [PW-1:0]    w_gidx, w_ptr_adv;
    logic             w_gcyc, w_gstb, w_stall, w_expire;
    logic [ADR_W-1:0] w_s_adr;
    logic [DAT_W-1:0] w_s_dat;
    logic [SEL_W-1:0] w_s_sel;

    wb_rr_arbiter_rr_pick #(.NM(NM), .PW(PW)) u_pick (
        .i_req (bus.m_cyc_i),
        .i_ptr (r_ptr),
        .o_gnt (w_pick)
    );

    always_comb begin
        w_gidx = '0;
        for (int k = 0; k < NM; k++)
            if (r_gnt[k]) w_gidx = PW'(k);
    end

    assign w_ptr_adv = (int'(w_gidx) == NM - 1) ? '0 : w_gidx + 1'b1;
    assign w_gcyc    = |(bus.m_cyc_i & r_gnt);
    assign w_gstb    = |(bus.m_stb_i & r_gnt);
    assign w_stall   = (r_state == ST_BUSY) && w_gstb && !bus.s_ack_i && !bus.s_err_i;
    assign w_expire  = WD_EN && w_stall && (r_wdog == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_ptr   <= w_ptr_next;
            r_wdog  <= w_wdog_next;
        end
    end

    // Dropping CYC always ends the tenure, even in the cycle the watchdog would expire.
    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (|bus.m_cyc_i) begin
                    w_gnt_next   = w_pick;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_gcyc) begin
                    w_state_next = ST_IDLE;
                    w_gnt_next   = '0;
                    w_ptr_next   = w_ptr_adv;
                end else if (w_expire) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_ERR, ST_DRAIN: begin
                if (!w_gcyc) begin
                    w_state_next = ST_IDLE;
                    w_gnt_next   = '0;
                    w_ptr_next   = w_ptr_adv;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        w_wdog_next = '0;
        if (w_stall && (w_state_next == ST_BUSY))
            w_wdog_next = (r_wdog == WD_MAX) ? r_wdog : r_wdog + 1'b1;
    end

    always_comb begin
        w_s_adr = '0;
        w_s_dat = '0;
        w_s_sel = '0;
        for (int k = 0; k < NM; k++) begin
            w_s_adr = w_s_adr | (bus.m_adr_i[k*ADR_W +: ADR_W] & {ADR_W{r_gnt[k]}});
            w_s_dat = w_s_dat | (bus.m_dat_i[k*DAT_W +: DAT_W] & {DAT_W{r_gnt[k]}});
            w_s_sel = w_s_sel | (bus.m_sel_i[k*SEL_W +: SEL_W] & {SEL_W{r_gnt[k]}});
        end
    end

    // Slave strobes only leave the arbiter in BUSY; ERR/DRAIN keep the slave idle and mute late ACKs.
    always_comb begin
        bus.s_adr_o = w_s_adr;
        bus.s_dat_o = w_s_dat;
        bus.s_sel_o = w_s_sel;
        bus.m_dat_o = (|r_gnt) ? bus.s_dat_i : '0;
        gnt_o       = r_gnt;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        timeout_o   = 1'b0;
        case (r_state)
            ST_BUSY: begin
                bus.s_cyc_o = w_gcyc;
                bus.s_stb_o = w_gstb;
                bus.s_we_o  = |(bus.m_we_i & r_gnt);
                bus.m_ack_o = r_gnt & {NM{bus.s_ack_i & ~bus.s_err_i}};
                bus.m_err_o = r_gnt & {NM{bus.s_err_i}};
            end
            ST_ERR: begin
                bus.m_err_o = r_gnt;
                timeout_o   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
